// File: rtl/ssb_pkg.sv
// rtl/ssb_pkg.sv - shared widths, limits, state encoding and cell-ID helper for SSB sync
package ssb_pkg;

    localparam int N_ID_1_MAX = 335;
    localparam int N_ID_MAX   = 1007;
    localparam int N_ID_1_W   = 9;
    localparam int N_ID_2_W   = 2;
    localparam int N_ID_W     = $clog2(N_ID_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_SYM = 3'd1,
        S_SKIP     = 3'd2,
        S_CAPTURE  = 3'd3,
        S_WAIT_DET = 3'd4
    } ssb_state_e;

    // N_id = 3*N_id_1 + N_id_2, widened first so 3*335+2 cannot wrap
    function automatic logic [N_ID_W-1:0] calc_n_id(
        input logic [N_ID_1_W-1:0] n_id_1,
        input logic [N_ID_2_W-1:0] n_id_2
    );
        return ({1'b0, n_id_1} * 10'd3) + {8'b0, n_id_2};
    endfunction

endpackage

// File: rtl/ssb_watchdog.sv
// rtl/ssb_watchdog.sv - cycle counter with clear and expire strobe for the SSB sync waits
module ssb_watchdog #(
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic en_i,
    input  logic clr_i,
    output logic expire_o
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count;

    // The clear cycle is the first cycle in the state, so it already counts as one
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            count <= '0;
        end else if (clr_i || !en_i) begin
            count <= en_i ? CW'(1) : '0;
        end else if (count != LAST) begin
            count <= count + CW'(1);
        end
    end

    assign expire_o = en_i && !clr_i && (count == LAST);

endmodule

// File: rtl/ssb_sync_ctrl.sv
// rtl/ssb_sync_ctrl.sv - SSB acquisition sequencer (PSS -> SSS gating -> cell ID); option SSB_SYNC_WATCHDOG_EN
module ssb_sync_ctrl
    import ssb_pkg::*;
#(
    parameter int SSS_START      = 64,
    parameter int SSS_LEN        = 127,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                peak_detected_i,
    input  logic [N_ID_2_W-1:0] N_id_2_i,
    input  logic                SSS_start_i,
    input  logic                SSS_valid_i,
    input  logic                SSS_bit_i,
    input  logic [N_ID_1_W-1:0] det_N_id_1_i,
    input  logic                det_valid_i,
    output logic [N_ID_2_W-1:0] N_id_2_o,
    output logic                N_id_2_valid_o,
    output logic                SSS_bit_o,
    output logic                SSS_bit_valid_o,
    output logic [N_ID_W-1:0]   N_id_o,
    output logic                N_id_valid_o,
    output logic                locked_o,
    output logic                error_o,
    output logic [2:0]          state_o
);

    localparam logic [2:0] IDLE     = S_IDLE;
    localparam logic [2:0] WAIT_SYM = S_WAIT_SYM;
    localparam logic [2:0] SKIP     = S_SKIP;
    localparam logic [2:0] CAPTURE  = S_CAPTURE;
    localparam logic [2:0] WAIT_DET = S_WAIT_DET;

    localparam logic [7:0] SKIP_LAST = 8'(SSS_START - 1);
    localparam logic [7:0] CAP_LAST  = 8'(SSS_LEN - 1);

    logic [2:0] state;
    logic [7:0] cnt;
    logic       timeout;

`ifdef SSB_SYNC_WATCHDOG_EN
    logic [2:0] state_d1;
    logic       wd_en;
    logic       wd_clr;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_d1 <= IDLE;
        end else begin
            state_d1 <= state;
        end
    end

    assign wd_en  = (state == WAIT_SYM) || (state == WAIT_DET);
    assign wd_clr = (state != state_d1);

    ssb_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .en_i     (wd_en),
        .clr_i    (wd_clr),
        .expire_o (timeout)
    );
`else
    assign timeout = (TIMEOUT_CYCLES < 0);
`endif

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state           <= IDLE;
            cnt             <= '0;
            N_id_2_o        <= '0;
            N_id_2_valid_o  <= 1'b0;
            SSS_bit_o       <= 1'b0;
            SSS_bit_valid_o <= 1'b0;
            N_id_o          <= '0;
            N_id_valid_o    <= 1'b0;
            locked_o        <= 1'b0;
            error_o         <= 1'b0;
        end else begin
            N_id_2_valid_o  <= 1'b0;
            SSS_bit_valid_o <= 1'b0;
            N_id_valid_o    <= 1'b0;
            error_o         <= 1'b0;

            case (state)
                IDLE: begin
                    if (peak_detected_i) begin
                        N_id_2_o       <= N_id_2_i;
                        N_id_2_valid_o <= 1'b1;
                        state          <= WAIT_SYM;
                    end
                end

                WAIT_SYM: begin
                    if (timeout) begin
                        error_o  <= 1'b1;
                        locked_o <= 1'b0;
                        state    <= IDLE;
                    end else if (SSS_start_i) begin
                        cnt   <= '0;
                        state <= SKIP;
                    end else if (peak_detected_i) begin
                        N_id_2_o       <= N_id_2_i;
                        N_id_2_valid_o <= 1'b1;
                    end
                end

                SKIP: begin
                    if (SSS_start_i) begin
                        error_o        <= 1'b1;
                        N_id_2_valid_o <= 1'b1;
                        cnt            <= '0;
                    end else if (SSS_valid_i) begin
                        if (cnt == SKIP_LAST) begin
                            cnt   <= '0;
                            state <= CAPTURE;
                        end else begin
                            cnt <= cnt + 8'd1;
                        end
                    end
                end

                CAPTURE: begin
                    // A new symbol start aborts this one and re-arms the detector
                    if (SSS_start_i) begin
                        error_o        <= 1'b1;
                        N_id_2_valid_o <= 1'b1;
                        cnt            <= '0;
                        state          <= SKIP;
                    end else if (SSS_valid_i) begin
                        SSS_bit_o       <= SSS_bit_i;
                        SSS_bit_valid_o <= 1'b1;
                        if (cnt == CAP_LAST) begin
                            cnt   <= '0;
                            state <= WAIT_DET;
                        end else begin
                            cnt <= cnt + 8'd1;
                        end
                    end
                end

                WAIT_DET: begin
                    if (timeout) begin
                        error_o  <= 1'b1;
                        locked_o <= 1'b0;
                        state    <= IDLE;
                    end else if (det_valid_i) begin
                        if (det_N_id_1_i <= N_ID_1_W'(N_ID_1_MAX)) begin
                            N_id_o       <= calc_n_id(det_N_id_1_i, N_id_2_o);
                            N_id_valid_o <= 1'b1;
                            locked_o     <= 1'b1;
                            state        <= WAIT_SYM;
                        end else begin
                            error_o  <= 1'b1;
                            locked_o <= 1'b0;
                            state    <= IDLE;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign state_o = state;

endmodule

// File: doc/ssb_sync_ctrl.md
# ssb_sync_ctrl

Controller that sequences SSB acquisition after the PSS correlator. It latches the detected N_id_2 and waits for the SSS symbol from the FFT demodulator. It gates exactly the SSS subcarriers as BPSK bits into the SSS detector, collects N_id_1 and publishes the cell ID N_id = 3·N_id_1 + N_id_2 to the channel estimator. It sits between PSS_detector/FFT_demod and SSS_detector/channel_estimator, replacing ad-hoc sequencing logic at receiver top level.

## Interface
Parameters:
- SSS_START, 64, index of first SSS subcarrier within the SSS symbol's valid-sample stream
- SSS_LEN, 127, number of SSS subcarriers forwarded
- TIMEOUT_CYCLES, 65535, watchdog limit in clock cycles (used only with watchdog compiled in)

Ports:
- clk_i  in  1  clock
- reset_i  in  1  asynchronous, active-high reset
- peak_detected_i  in  1  PSS peak strobe, one cycle
- N_id_2_i  in  2  N_id_2 qualified by peak_detected_i
- SSS_start_i  in  1  strobe, SSS symbol output about to start
- SSS_valid_i  in  1  one FFT bin valid
- SSS_bit_i  in  1  MSB of the real part of the current bin
- det_N_id_1_i  in  9  SSS detector result
- det_valid_i  in  1  result strobe
- N_id_2_o  out  2  latched N_id_2
- N_id_2_valid_o  out  1  one-cycle pulse, arms the SSS detector
- SSS_bit_o  out  1  forwarded bit
- SSS_bit_valid_o  out  1  forwarded bit qualifier
- N_id_o  out  10  cell ID
- N_id_valid_o  out  1  one-cycle pulse
- locked_o  out  1  level, a valid N_id is held
- error_o  out  1  one-cycle pulse: N_id_1 > 335, aborted capture, or timeout
- state_o  out  3  debug, current state encoding

## Operation
States and transitions:
- **IDLE (0)**
  - On peak_detected_i: latch N_id_2_i, pulse N_id_2_valid_o, go to WAIT_SYM.
- **WAIT_SYM (1)**
  - On SSS_start_i: clear cnt, go to SKIP.
  - On peak_detected_i with no SSS_start_i: re-latch N_id_2 and re-pulse N_id_2_valid_o.
- **SKIP (2)**
  - Count SSS_valid_i samples; valid samples 0..SSS_START-1 are discarded.
  - On the valid sample with cnt == SSS_START-1: clear cnt, go to CAPTURE.
- **CAPTURE (3)**
  - Each SSS_valid_i forwards SSS_bit_i.
  - After SSS_LEN bits have been forwarded, go to WAIT_DET.
- **WAIT_DET (4)**
  - On det_valid_i with det_N_id_1_i ≤ 335: N_id_o ← 3·det_N_id_1_i + N_id_2; pulse N_id_valid_o; set locked_o; go to WAIT_SYM to track the next SSB.
  - On det_valid_i with det_N_id_1_i > 335: pulse error_o, clear locked_o, go to IDLE.

Rules and boundary conditions:
- cnt is 8 bits and covers SSS_START+SSS_LEN ≤ 255.
- N_id arithmetic is done in 10 bits without overflow; the maximum is 1007.
- peak_detected_i is ignored in SKIP, CAPTURE and WAIT_DET.
- SSS_start_i during SKIP or CAPTURE:
  - Pulse error_o and re-pulse N_id_2_valid_o to re-arm the detector.
  - Clear cnt and restart SKIP.
  - No further bits from the old symbol are forwarded.
- SSS_start_i in IDLE or WAIT_DET is ignored.
- det_valid_i outside WAIT_DET is ignored.
- Reset mid-operation returns to IDLE immediately. Forwarding stops the same cycle, because the outputs are flops cleared asynchronously.

## Timing
- Reset values: every output is 0; the state is IDLE.
- All outputs are registered.
- N_id_2_valid_o pulses the cycle after peak_detected_i.
- SSS_bit_o / SSS_bit_valid_o follow SSS_bit_i / SSS_valid_i with 1-cycle latency. SSS_bit_valid_o is exactly SSS_LEN pulses per capture.
- N_id_valid_o pulses 1 cycle after det_valid_i; N_id_o is stable from that cycle until the next update.
- State change takes effect the cycle after the triggering input.
- Gaps in SSS_valid_i are allowed; counting is per valid sample only.

## Configuration
- SSB_SYNC_WATCHDOG_EN defined:
  - A cycle counter runs in WAIT_SYM and WAIT_DET and is cleared on every state change.
  - Reaching TIMEOUT_CYCLES: go to IDLE, clear locked_o, pulse error_o.
- Not defined: no counter; WAIT_SYM and WAIT_DET wait indefinitely; TIMEOUT_CYCLES is unused.

## Structure
- Shared package ssb_pkg:
  - state enum (IDLE, WAIT_SYM, SKIP, CAPTURE, WAIT_DET)
  - N_ID_1_MAX = 335, N_ID_MAX = 1007
  - widths: N_ID_1_W = 9, N_ID_W = 10, N_ID_2_W = 2
- One sub-module, ssb_watchdog (cycle counter with clear and expire strobe), instantiated only under SSB_SYNC_WATCHDOG_EN.

## Test plan
- **Nominal acquisition:** peak with N_id_2 = 2, SSS_start, 256 contiguous valids carrying an alternating bit pattern, det_valid with N_id_1 = 100 → N_id_2_valid pulse; exactly 127 bit pulses, the first carrying input bin 64; N_id_o = 302, locked_o = 1, state_o = 1.
- **Gapped stream:** SSS_valid_i deasserted every other cycle → same 127 bits in order; the last forwarded bit is bin 190.
- **Invalid detector result:** det_N_id_1_i = 400 → error_o pulse, locked_o = 0, state_o = 0, no N_id_valid_o.
- **Premature SSS_start:** SSS_start_i after 30 captured bits → error_o pulse, re-armed N_id_2_valid_o; the subsequent capture yields a full 127 bits.
- **Reset mid-operation:** reset_i asserted during CAPTURE → all outputs 0 at once; no bit pulses after release until a new peak.
- **Watchdog timeout:** with SSB_SYNC_WATCHDOG_EN and TIMEOUT_CYCLES = 100, no SSS_start after the peak → at cycle 100 in WAIT_SYM, error_o pulse and state_o = 0. Without the macro the block stays in WAIT_SYM.
